// File: rtl/serial_frame_rx_if.sv
// Serial ingest bundle: qualified bit stream in, deserialised payload words and framing strobes out.
// The receiver uses the slave modport and the source/consumer side uses the master modport.
interface serial_frame_rx_if #(
    parameter int WORD_W = 8
);
    logic              serial_data;
    logic              data_ena;
    logic              clear;
    logic [WORD_W-1:0] word;
    logic              word_valid;
    logic [7:0]        word_idx;
    logic              header_found;
    logic              hdr_id;
    logic              in_frame;
    logic              frame_done;

    modport slave (
        input  serial_data, data_ena, clear,
        output word, word_valid, word_idx, header_found, hdr_id, in_frame, frame_done
    );

    modport master (
        output serial_data, data_ena, clear,
        input  word, word_valid, word_idx, header_found, hdr_id, in_frame, frame_done
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: slides a bit window to find header A/B at any alignment, then
// deserialises PAYLOAD_WORDS words aligned to that header with per-word strobes.
module serial_frame_rx #(
    parameter int              WORD_W        = 8,
    parameter bit              LSB_FIRST     = 1'b1,
    parameter logic [WORD_W-1:0] HDR_A       = 8'hA5,
    parameter logic [WORD_W-1:0] HDR_B       = 8'hC3,
    parameter int              PAYLOAD_WORDS = 4
) (
    input  logic               clk_50,
    input  logic               reset_n,
    serial_frame_rx_if.slave   rx
);

    typedef enum logic [0:0] {
        ST_HUNT    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    localparam logic [5:0] FILL_MAX = 6'(WORD_W);
    localparam logic [5:0] LAST_BIT = 6'(WORD_W - 1);
    localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_WORDS - 1);

    state_t              state_r, state_nx_s;
    logic [WORD_W-1:0]   window_r, window_nx_s, shifted_s;
    logic [5:0]          fill_r, fill_nx_s;
    logic [5:0]          bit_cnt_r, bit_cnt_nx_s;
    logic [7:0]          idx_r, idx_nx_s;
    logic [WORD_W-1:0]   word_r, word_nx_s;
    logic [7:0]          word_idx_r, word_idx_nx_s;
    logic                hdr_id_r, hdr_id_nx_s;
    logic                word_valid_r, word_valid_nx_s;
    logic                header_found_r, header_found_nx_s;
    logic                frame_done_r, frame_done_nx_s;
    logic                in_frame_r, in_frame_nx_s;
    logic                hit_a_s, hit_b_s, hunt_ready_s;

    function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] win, input logic b);
        if (LSB_FIRST) begin
            shift_in = {b, win[WORD_W-1:1]};
        end else begin
            shift_in = {win[WORD_W-2:0], b};
        end
    endfunction

    // Window including the current bit; header match looks at this, not the stored window.
    always_comb begin
        shifted_s    = shift_in(window_r, rx.serial_data);
        hit_a_s      = (shifted_s == HDR_A);
        hit_b_s      = (shifted_s == HDR_B);
        hunt_ready_s = (fill_r >= LAST_BIT);
    end

    // State register.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state, datapath and strobe decode; clear overrides any bit arriving this cycle.
    always_comb begin
        state_nx_s        = state_r;
        window_nx_s       = window_r;
        fill_nx_s         = fill_r;
        bit_cnt_nx_s      = bit_cnt_r;
        idx_nx_s          = idx_r;
        word_nx_s         = word_r;
        word_idx_nx_s     = word_idx_r;
        hdr_id_nx_s       = hdr_id_r;
        word_valid_nx_s   = 1'b0;
        header_found_nx_s = 1'b0;
        frame_done_nx_s   = 1'b0;
        if (rx.clear) begin
            state_nx_s   = ST_HUNT;
            window_nx_s  = '0;
            fill_nx_s    = 6'd0;
            bit_cnt_nx_s = 6'd0;
            idx_nx_s     = 8'd0;
        end else if (rx.data_ena) begin
            window_nx_s = shifted_s;
            case (state_r)
                ST_HUNT: begin
                    fill_nx_s = (fill_r == FILL_MAX) ? fill_r : fill_r + 6'd1;
                    if (hunt_ready_s && (hit_a_s || hit_b_s)) begin
                        state_nx_s        = ST_PAYLOAD;
                        header_found_nx_s = 1'b1;
                        hdr_id_nx_s       = ~hit_a_s;
                        bit_cnt_nx_s      = 6'd0;
                        idx_nx_s          = 8'd0;
                        window_nx_s       = '0;
                        fill_nx_s         = 6'd0;
                    end else begin
                        state_nx_s = ST_HUNT;
                    end
                end
                ST_PAYLOAD: begin
                    if (bit_cnt_r == LAST_BIT) begin
                        word_nx_s       = shifted_s;
                        word_valid_nx_s = 1'b1;
                        word_idx_nx_s   = idx_r;
                        bit_cnt_nx_s    = 6'd0;
                        if (idx_r == LAST_IDX) begin
                            // Last word: the next header must be built from fresh bits only.
                            state_nx_s      = ST_HUNT;
                            frame_done_nx_s = 1'b1;
                            window_nx_s     = '0;
                            fill_nx_s       = 6'd0;
                            idx_nx_s        = 8'd0;
                        end else begin
                            idx_nx_s = idx_r + 8'd1;
                        end
                    end else begin
                        bit_cnt_nx_s = bit_cnt_r + 6'd1;
                    end
                end
                default: begin
                    state_nx_s  = ST_HUNT;
                    window_nx_s = '0;
                    fill_nx_s   = 6'd0;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
        in_frame_nx_s = (state_nx_s == ST_PAYLOAD);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            window_r       <= '0;
            fill_r         <= 6'd0;
            bit_cnt_r      <= 6'd0;
            idx_r          <= 8'd0;
            word_r         <= '0;
            word_idx_r     <= 8'd0;
            hdr_id_r       <= 1'b0;
            word_valid_r   <= 1'b0;
            header_found_r <= 1'b0;
            frame_done_r   <= 1'b0;
            in_frame_r     <= 1'b0;
        end else begin
            window_r       <= window_nx_s;
            fill_r         <= fill_nx_s;
            bit_cnt_r      <= bit_cnt_nx_s;
            idx_r          <= idx_nx_s;
            word_r         <= word_nx_s;
            word_idx_r     <= word_idx_nx_s;
            hdr_id_r       <= hdr_id_nx_s;
            word_valid_r   <= word_valid_nx_s;
            header_found_r <= header_found_nx_s;
            frame_done_r   <= frame_done_nx_s;
            in_frame_r     <= in_frame_nx_s;
        end
    end

    assign rx.word         = word_r;
    assign rx.word_valid   = word_valid_r;
    assign rx.word_idx     = word_idx_r;
    assign rx.header_found = header_found_r;
    assign rx.hdr_id       = hdr_id_r;
    assign rx.in_frame     = in_frame_r;
    assign rx.frame_done   = frame_done_r;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed bit streams into two configurations, expected strobes
// queued with their due cycle and checked by per-instance monitors.
module tb_serial_frame_rx;

    logic clk_50 = 1'b0;
    logic rst0_n = 1'b0;
    logic rst1_n = 1'b0;
    always #10 clk_50 = ~clk_50;

    serial_frame_rx_if #(.WORD_W(8))  if0 ();
    serial_frame_rx_if #(.WORD_W(12)) if1 ();

    serial_frame_rx #(
        .WORD_W(8), .LSB_FIRST(1'b1), .HDR_A(8'hA5), .HDR_B(8'hC3), .PAYLOAD_WORDS(4)
    ) dut0 (
        .clk_50(clk_50), .reset_n(rst0_n), .rx(if0.slave)
    );

    serial_frame_rx #(
        .WORD_W(12), .LSB_FIRST(1'b0), .HDR_A(12'hABC), .HDR_B(12'h5A5), .PAYLOAD_WORDS(2)
    ) dut1 (
        .clk_50(clk_50), .reset_n(rst1_n), .rx(if1.slave)
    );

    typedef struct {
        bit          is_hdr;
        logic [31:0] data;
        int          idx;
        bit          last;
        bit          hid;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_cyc = 0;
    int   slot     = 0;
    bit   gap_mode = 1'b0;

    always @(posedge clk_50) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Only the selected instance sees the bit; the other is held idle.
    task automatic drive(input int d, input logic b, input logic en, input logic clr);
        if0.serial_data = (d == 0) ? b   : 1'b0;
        if0.data_ena    = (d == 0) ? en  : 1'b0;
        if0.clear       = (d == 0) ? clr : 1'b0;
        if1.serial_data = (d == 1) ? b   : 1'b0;
        if1.data_ena    = (d == 1) ? en  : 1'b0;
        if1.clear       = (d == 1) ? clr : 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_50);
            drive(0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // In gap mode enabled slots follow the repeating 1,0,0,1 pattern.
    task automatic send_bit(input int d, input logic b);
        if (gap_mode) begin
            while ((slot % 4 == 1) || (slot % 4 == 2)) begin
                @(negedge clk_50);
                drive(d, ~b, 1'b0, 1'b0);
                slot++;
            end
        end
        @(negedge clk_50);
        drive(d, b, 1'b1, 1'b0);
        slot++;
        last_cyc = cyc + 1;
    endtask

    task automatic send_word(input int d, input logic [31:0] v, input int w, input bit lsb);
        for (int i = 0; i < w; i++) begin
            send_bit(d, lsb ? v[i] : v[w-1-i]);
        end
    endtask

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic expect_hdr(input int d, input bit hid);
        exp_t e;
        e.is_hdr = 1'b1; e.data = 32'd0; e.idx = 0; e.last = 1'b0; e.hid = hid; e.cyc = last_cyc;
        push(d, e);
    endtask

    task automatic expect_word(input int d, input logic [31:0] v, input int idx, input bit last);
        exp_t e;
        e.is_hdr = 1'b0; e.data = v; e.idx = idx; e.last = last; e.hid = 1'b0; e.cyc = last_cyc;
        push(d, e);
    endtask

    // Full default-configuration frame; payload bytes read left to right in pay.
    task automatic frame8(input logic [7:0] hdr, input bit hid, input logic [31:0] pay);
        send_word(0, 32'(hdr), 8, 1'b1);
        expect_hdr(0, hid);
        for (int i = 0; i < 4; i++) begin
            send_word(0, 32'(pay[31-8*i -: 8]), 8, 1'b1);
            expect_word(0, 32'(pay[31-8*i -: 8]), i, i == 3);
        end
    endtask

    task automatic mon(input int d, input logic hf, input logic hid, input logic wv,
                       input logic [31:0] w, input logic [7:0] wi, input logic fd);
        exp_t e;
        bit   empty;
        if (fd && !wv) chk($sformatf("frame_done_alone_dut%0d", d), 32'(fd), 32'd0);
        if (hf || wv) begin
            empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe_dut%0d: got header_found=%0b word_valid=%0b word=%0h, expected none (cycle %0d)",
                         d, hf, wv, w, cyc);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("strobe_kind_dut%0d", d), 32'(hf), 32'(e.is_hdr));
                chk($sformatf("strobe_cycle_dut%0d", d), 32'(cyc), 32'(e.cyc));
                if (e.is_hdr) begin
                    chk($sformatf("hdr_id_dut%0d", d), 32'(hid), 32'(e.hid));
                end else begin
                    chk($sformatf("word_dut%0d", d), w, e.data);
                    chk($sformatf("word_idx_dut%0d", d), 32'(wi), 32'(e.idx));
                    chk($sformatf("frame_done_dut%0d", d), 32'(fd), 32'(e.last));
                end
            end
        end
    endtask

    always @(negedge clk_50) begin
        if (rst0_n) mon(0, if0.header_found, if0.hdr_id, if0.word_valid, 32'(if0.word), if0.word_idx, if0.frame_done);
        if (rst1_n) mon(1, if1.header_found, if1.hdr_id, if1.word_valid, 32'(if1.word), if1.word_idx, if1.frame_done);
    end

    task automatic chk_cleared(input int d, input string tag);
        if (d == 0) begin
            chk({tag, "_word"}, 32'(if0.word), 32'd0);
            chk({tag, "_idx"}, 32'(if0.word_idx), 32'd0);
            chk({tag, "_flags"}, 32'({if0.hdr_id, if0.word_valid, if0.header_found, if0.in_frame, if0.frame_done}), 32'd0);
        end else begin
            chk({tag, "_word"}, 32'(if1.word), 32'd0);
            chk({tag, "_idx"}, 32'(if1.word_idx), 32'd0);
            chk({tag, "_flags"}, 32'({if1.hdr_id, if1.word_valid, if1.header_found, if1.in_frame, if1.frame_done}), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk_50);
        chk_cleared(0, "reset_dut0");
        chk_cleared(1, "reset_dut1");
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        idle(2);

        // 1: A5 header then 11,22,33,44; in_frame high inside, low after.
        send_word(0, 32'h0A5, 8, 1'b1);
        expect_hdr(0, 1'b0);
        idle(1);
        chk("in_frame_after_hdr", 32'(if0.in_frame), 32'd1);
        for (int i = 0; i < 4; i++) begin
            send_word(0, 32'h11 * (i + 1), 8, 1'b1);
            expect_word(0, 32'h11 * (i + 1), i, i == 3);
        end
        idle(1);
        chk("in_frame_after_frame", 32'(if0.in_frame), 32'd0);
        idle(3);

        // 2: three junk bits then C3 header, payload aligned to the header.
        send_bit(0, 1'b0); send_bit(0, 1'b1); send_bit(0, 1'b0);
        frame8(8'hC3, 1'b1, 32'h5A0FF081);
        idle(3);

        // 3: same frame as 1 with the enable gapped.
        gap_mode = 1'b1;
        slot     = 0;
        frame8(8'hA5, 1'b0, 32'h11223344);
        gap_mode = 1'b0;
        idle(3);

        // 4: header value inside payload is ignored; next frame back to back.
        frame8(8'hA5, 1'b0, 32'hA5A500FF);
        frame8(8'hA5, 1'b0, 32'h01020304);
        idle(3);

        // 5: clear on the completing bit of word 2.
        send_word(0, 32'h0A5, 8, 1'b1);
        expect_hdr(0, 1'b0);
        send_word(0, 32'h11, 8, 1'b1);
        expect_word(0, 32'h11, 0, 1'b0);
        send_word(0, 32'h22, 8, 1'b1);
        expect_word(0, 32'h22, 1, 1'b0);
        send_word(0, 32'h33, 7, 1'b1);
        @(negedge clk_50);
        drive(0, 1'b0, 1'b1, 1'b1);
        idle(1);
        chk("clear_in_frame", 32'(if0.in_frame), 32'd0);
        chk("clear_word_hold", 32'(if0.word), 32'h22);
        chk("clear_idx_hold", 32'(if0.word_idx), 32'd1);
        idle(2);
        frame8(8'hA5, 1'b0, 32'h44556677);
        idle(3);

        // 6: 12-bit MSB-first instance, then async reset in mid-word.
        send_word(1, 32'hABC, 12, 1'b0);
        expect_hdr(1, 1'b0);
        send_word(1, 32'h123, 12, 1'b0);
        expect_word(1, 32'h123, 0, 1'b0);
        send_word(1, 32'h456, 12, 1'b0);
        expect_word(1, 32'h456, 1, 1'b1);
        idle(1);
        chk("w12_in_frame_after", 32'(if1.in_frame), 32'd0);
        chk("w12_word_hold", 32'(if1.word), 32'h456);
        send_word(1, 32'h5A5, 12, 1'b0);
        expect_hdr(1, 1'b1);
        idle(1);
        chk("w12_in_frame_hdr_b", 32'(if1.in_frame), 32'd1);
        send_word(1, 32'h789, 5, 1'b0);
        #3;
        rst1_n = 1'b0;
        #1;
        chk_cleared(1, "async_reset_dut1");
        idle(2);
        rst1_n = 1'b1;
        send_word(1, 32'hABC, 12, 1'b0);
        expect_hdr(1, 1'b0);
        send_word(1, 32'h0AA, 12, 1'b0);
        expect_word(1, 32'h0AA, 0, 1'b0);
        send_word(1, 32'h0BB, 12, 1'b0);
        expect_word(1, 32'h0BB, 1, 1'b1);
        idle(4);

        chk("queue0_drained", 32'(q0.size()), 32'd0);
        chk("queue1_drained", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
Parametrised serial-to-parallel frame receiver for the serial ingest path. It hunts bit-by-bit for one of two programmable header words at any bit alignment. It then deserialises a fixed number of payload words aligned to that header and strobes each word out, flagging header type and end of frame. It is a successor to the fixed 8-bit word/header detector, adding width, bit order, realignment, framing and per-word valid.

Parameters:
WORD_W, 8, bits per word and header width (2..32)
LSB_FIRST, 1, 1 = first serial bit lands in word[0] (shift right in at MSB); 0 = first bit lands in word[WORD_W-1] (shift left in at LSB)
HDR_A, 8'hA5, header value A (WORD_W bits)
HDR_B, 8'hC3, header value B (WORD_W bits); may equal HDR_A, in which case A wins
PAYLOAD_WORDS, 4, payload words per frame following a header (1..255)

Ports:
clk_50  input  1  system clock, 50 MHz, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
serial_data  input  1  serial bit, sampled only when data_ena=1
data_ena  input  1  qualifies serial_data for this clock
clear  input  1  synchronous abort; returns to HUNT, higher priority than data_ena
word  output  WORD_W  last completed payload word, held between strobes
word_valid  output  1  one-cycle strobe: word is new
word_idx  output  8  index (0..PAYLOAD_WORDS-1) of word, valid with word_valid, held
header_found  output  1  one-cycle strobe on header match
hdr_id  output  1  0 = HDR_A matched, 1 = HDR_B; updated with header_found, held
in_frame  output  1  1 while in PAYLOAD state
frame_done  output  1  one-cycle strobe, coincident with word_valid of last payload word

Behaviour:
- Reset (async, reset_n=0): state HUNT; shift window=0, fill count=0, bit count=0. Outputs: word=0, word_idx=0, hdr_id=0, and word_valid, header_found, in_frame, frame_done all 0.
- Shift: on each clock with data_ena=1 and clear=0, next_window = LSB_FIRST ? {serial_data, window[WORD_W-1:1]} : {window[WORD_W-2:0], serial_data}. No shift when data_ena=0; strobes deassert.
- HUNT: fill count saturates at WORD_W. Match is tested on next_window (including the current bit) only when fill count ≥ WORD_W-1 before the shift, i.e. at least WORD_W bits since entering HUNT.
  - On match, next edge: header_found=1, hdr_id set (A has priority), state→PAYLOAD, in_frame=1, bit count=0, word index=0, window cleared.
  - No match: keep sliding one bit per enabled clock (arbitrary alignment).
- PAYLOAD: bit count increments per enabled bit. On the WORD_W-th bit, next edge: word=next_window, word_valid=1, word_idx=current index, bit count=0, index+1.
  - If the index was PAYLOAD_WORDS-1: frame_done=1 same cycle, state→HUNT, in_frame=0, window and fill count cleared.
  - Header values inside payload are ignored.
- Latency: one clk_50 from the enabled edge sampling the completing bit to the strobe. A back-to-back next frame needs a full new header (no overlap with previous payload bits).
- clear=1: next edge state→HUNT; window, fill, bit count and index cleared; in_frame=0. Strobes are 0 that cycle even if the completing bit is present. word/word_idx/hdr_id hold.
- Reset mid-frame: immediate return to reset values; partial word discarded.
- data_ena gaps of any length within a word or header are tolerated; bit counting resumes.
- All strobes are single-cycle; outputs registered, no combinational path from inputs.

Test Plan:
1. Defaults. Reset, then send LSB-first bits 1,0,1,0,0,1,0,1 (A5), then payload bytes 11,22,33,44 -> header_found pulse with hdr_id=0. Four word_valid pulses, word=11,22,33,44, word_idx=0..3; frame_done with 44; in_frame low after.
2. Misalignment. 3 random junk bits before C3 header -> header_found one cycle after the 8th header bit, hdr_id=1, payload correctly aligned.
3. Gaps. data_ena toggled 1,0,0,1 pattern through header+payload -> identical words/indices to scenario 1; strobes only after enabled completing bits.
4. Payload containing A5 (payload A5,A5,00,FF) -> no extra header_found; 4 word_valid; then immediate second A5 frame detected only after 8 fresh bits.
5. clear asserted on the 8th bit of payload word 2 -> no word_valid, in_frame=0 next cycle, word holds 22; new header accepted afterwards.
6. LSB_FIRST=0, WORD_W=12, HDR_A=12'hABC, PAYLOAD_WORDS=2: MSB-first header then 123, 456 -> words 123, 456, frame_done on second. Async reset mid-word clears all outputs immediately.
